snake_mover: RTL and testbench

Upstream stage of the collision checker: owns the snake body and advances it one grid step per game tick. It accepts player direction and grow requests, maintains packed head-first segment coordinates plus the current length, and presents them registered to the collision stage and the renderer. Segment 0 is the head, in bits [10:0] of each bus.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_head_step.sv | 92 +++++++++
 rtl/snake_mover.sv | 146 ++++++++++++++
 tb/tb_snake_mover.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared widths, direction/state types and helpers for the snake mover
package snake_pkg;

    localparam int COORD_W = 11;
    localparam int LEN_W   = 6;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HALT = ST_HALT
    } state_t;

    // The encoding places opposite directions two apart, so flipping bit 1 reverses.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_head_step.sv
// rtl/snake_head_step.sv - combinational one-grid-step head advance with edge detection
//
// Ports:
//   x, y            current head coordinate (unsigned, COORD_W bits)
//   dir             direction to step in
//   next_x, next_y  stepped head coordinate
//   at_edge         the step would leave the play field
//
// Build option SNAKE_WRAP_EN: when defined the head wraps to the opposite
// edge; otherwise a step off the field returns the current coordinate.
module snake_head_step
    import snake_pkg::*;
#(
    parameter int STEP  = 20,
    parameter int X_MAX = 640,
    parameter int Y_MAX = 480
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_t               dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               at_edge
);

    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
    localparam logic [COORD_W:0]   STEP_W = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0]   X_LIM  = (COORD_W + 1)'(X_MAX);
    localparam logic [COORD_W:0]   Y_LIM  = (COORD_W + 1)'(Y_MAX);

    logic hit_up, hit_down, hit_left, hit_right;
    logic [COORD_W-1:0] edge_up, edge_down, edge_left, edge_right;

    // One extra bit on the additive checks so a step near 2^11 cannot alias.
    assign hit_up    = (y < STEP_C);
    assign hit_left  = (x < STEP_C);
    assign hit_down  = (({1'b0, y} + STEP_W) >= Y_LIM);
    assign hit_right = (({1'b0, x} + STEP_W) >= X_LIM);

`ifdef SNAKE_WRAP_EN
    assign edge_up    = COORD_W'(Y_MAX - STEP);
    assign edge_down  = '0;
    assign edge_left  = COORD_W'(X_MAX - STEP);
    assign edge_right = '0;
`else
    assign edge_up    = y;
    assign edge_down  = y;
    assign edge_left  = x;
    assign edge_right = x;
`endif

    always_comb begin
        next_x  = x;
        next_y  = y;
        at_edge = 1'b0;
        case (dir)
            UP: begin
                if (hit_up) begin
                    at_edge = 1'b1;
                    next_y  = edge_up;
                end else begin
                    next_y = y - STEP_C;
                end
            end
            RIGHT: begin
                if (hit_right) begin
                    at_edge = 1'b1;
                    next_x  = edge_right;
                end else begin
                    next_x = x + STEP_C;
                end
            end
            DOWN: begin
                if (hit_down) begin
                    at_edge = 1'b1;
                    next_y  = edge_down;
                end else begin
                    next_y = y + STEP_C;
                end
            end
            default: begin
                if (hit_left) begin
                    at_edge = 1'b1;
                    next_x  = edge_left;
                end else begin
                    next_x = x - STEP_C;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_mover.sv
// rtl/snake_mover.sv - snake body owner: direction filter, grow latch, per-tick shift
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   start           pulse, IDLE -> RUN
//   freeze          level, RUN -> HALT (left only by reset)
//   move_tick       pulse, advances the body one grid step while running
//   dir_in          requested direction (0 up, 1 right, 2 down, 3 left)
//   grow            pulse, lengthens the snake on the next move
//   snakepos_x/y    packed segment coordinates, segment 0 (head) in [10:0]
//   length          active segment count
//   moved           one-cycle pulse when new positions appear
//   edge_hit        one-cycle pulse with moved when a step was blocked at
//                   the field edge (present only without SNAKE_WRAP_EN)
//
// Build option SNAKE_WRAP_EN: head wraps at the field edges and edge_hit
// is removed.
module snake_mover
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = 23,
    parameter int STEP      = 20,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int START_X   = 320,
    parameter int START_Y   = 240,
    parameter int START_LEN = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       freeze,
    input  logic                       move_tick,
    input  logic [1:0]                 dir_in,
    input  logic                       grow,
    output logic [COORD_W*MAX_LEN-1:0] snakepos_x,
    output logic [COORD_W*MAX_LEN-1:0] snakepos_y,
    output logic [LEN_W-1:0]           length,
    output logic                       moved
`ifndef SNAKE_WRAP_EN
    ,
    output logic                       edge_hit
`endif
);

`ifdef SNAKE_WRAP_EN
    localparam logic EDGE_BLOCKS = 1'b0;
`else
    localparam logic EDGE_BLOCKS = 1'b1;
`endif

    state_t             state;
    dir_t               dir_q;
    dir_t               dir_req;
    dir_t               dir_eff;
    logic               grow_pend;
    logic               grow_eff;
    logic [LEN_W-1:0]   len_q;
    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic               at_edge;
    logic               blocked;
    logic               do_move;

    // A reversal request is dropped; any other request takes effect in the
    // same cycle, so a tick sees a direction presented alongside it.
    assign dir_req  = dir_t'(dir_in);
    assign dir_eff  = (dir_req == opposite(dir_q)) ? dir_q : dir_req;
    assign grow_eff = grow_pend | grow;
    assign do_move  = (state == RUN) && move_tick && !freeze;
    assign blocked  = at_edge & EDGE_BLOCKS;

    snake_head_step #(
        .STEP  (STEP),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_head_step (
        .x       (seg_x[0]),
        .y       (seg_y[0]),
        .dir     (dir_eff),
        .next_x  (head_x),
        .next_y  (head_y),
        .at_edge (at_edge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= COORD_W'(START_X - i * STEP);
                seg_y[i] <= COORD_W'(START_Y);
            end
            len_q     <= LEN_W'(START_LEN);
            dir_q     <= RIGHT;
            grow_pend <= 1'b0;
            state     <= IDLE;
            moved     <= 1'b0;
        end else begin
            dir_q <= dir_eff;
            moved <= do_move;

            case (state)
                IDLE:    if (start)  state <= RUN;
                RUN:     if (freeze) state <= HALT;
                default: state <= HALT;
            endcase

            // A blocked step leaves the body (and any pending growth) intact.
            if (do_move && !blocked) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0]  <= head_x;
                seg_y[0]  <= head_y;
                grow_pend <= 1'b0;
                // The full shift already carries the old tail one slot back,
                // so growing is just exposing one more slot.
                if (grow_eff && (len_q < LEN_W'(MAX_LEN))) begin
                    len_q <= len_q + 1'b1;
                end
            end else if (grow) begin
                grow_pend <= 1'b1;
            end
        end
    end

`ifndef SNAKE_WRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_hit <= 1'b0;
        end else begin
            edge_hit <= do_move & blocked;
        end
    end
`endif

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign snakepos_x[COORD_W*g +: COORD_W] = seg_x[g];
        assign snakepos_y[COORD_W*g +: COORD_W] = seg_y[g];
    end

    assign length = len_q;

endmodule

// File: tb/tb_snake_mover.sv
// tb/tb_snake_mover.sv - scoreboard bench for snake_mover against a grid-rule reference model
module tb_snake_mover;

    localparam int MAX_LEN   = 23;
    localparam int STEP      = 20;
    localparam int X_MAX     = 640;
    localparam int Y_MAX     = 480;
    localparam int START_X   = 320;
    localparam int START_Y   = 240;
    localparam int START_LEN = 3;
    localparam int W         = 11 * MAX_LEN;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         freeze = 1'b0;
    logic         move_tick = 1'b0;
    logic         grow = 1'b0;
    logic [1:0]   dir_in = 2'd1;
    logic [W-1:0] snakepos_x;
    logic [W-1:0] snakepos_y;
    logic [5:0]   length;
    logic         moved;
    logic         edge_hit;

    snake_mover #(
        .MAX_LEN   (MAX_LEN),
        .STEP      (STEP),
        .X_MAX     (X_MAX),
        .Y_MAX     (Y_MAX),
        .START_X   (START_X),
        .START_Y   (START_Y),
        .START_LEN (START_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .freeze     (freeze),
        .move_tick  (move_tick),
        .dir_in     (dir_in),
        .grow       (grow),
        .snakepos_x (snakepos_x),
        .snakepos_y (snakepos_y),
        .length     (length),
        .moved      (moved)
`ifndef SNAKE_WRAP_EN
        ,
        .edge_hit   (edge_hit)
`endif
    );

`ifdef SNAKE_WRAP_EN
    assign edge_hit = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [5:0]   len;
        logic         hit;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: body as plain integer coordinate lists.
    int m_x[MAX_LEN];
    int m_y[MAX_LEN];
    int m_len, m_dir, m_pend, m_state;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack_x();
        logic [W-1:0] r;
        for (int i = 0; i < MAX_LEN; i++) r[11*i +: 11] = 11'(m_x[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] pack_y();
        logic [W-1:0] r;
        for (int i = 0; i < MAX_LEN; i++) r[11*i +: 11] = 11'(m_y[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_LEN; i++) begin
            m_x[i] = (START_X - i * STEP) & 2047;
            m_y[i] = START_Y;
        end
        m_len   = START_LEN;
        m_dir   = 1;
        m_pend  = 0;
        m_state = 0;
    endtask

    // Applies one clock edge worth of game rules to the model.
    task automatic model_edge(input bit st, input bit fr, input bit tk, input int d, input bit g);
        int nx, ny, eff;
        bit mv, blk;
        eff = (d == (m_dir ^ 2)) ? m_dir : d;
        mv  = (m_state == 1) && tk && !fr;
        if (mv) begin
            nx = m_x[0];
            ny = m_y[0];
            case (eff)
                0:       ny -= STEP;
                1:       nx += STEP;
                2:       ny += STEP;
                default: nx -= STEP;
            endcase
`ifdef SNAKE_WRAP_EN
            nx  = (nx + X_MAX) % X_MAX;
            ny  = (ny + Y_MAX) % Y_MAX;
            blk = 1'b0;
`else
            blk = (nx < 0) || (nx >= X_MAX) || (ny < 0) || (ny >= Y_MAX);
`endif
            if (!blk) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    m_x[i] = m_x[i-1];
                    m_y[i] = m_y[i-1];
                end
                m_x[0] = nx;
                m_y[0] = ny;
                if ((m_pend != 0 || g) && m_len < MAX_LEN) m_len++;
                m_pend = 0;
            end else if (g) begin
                m_pend = 1;
            end
            sb.push_back('{x: pack_x(), y: pack_y(), len: 6'(m_len), hit: blk, cyc: cyc + 1});
        end else if (g) begin
            m_pend = 1;
        end
        if (m_state == 0 && st)      m_state = 1;
        else if (m_state == 1 && fr) m_state = 2;
        m_dir = eff;
    endtask

    task automatic drive(input bit st, input bit fr, input bit tk, input bit g, input int d);
        @(negedge clk);
        start     = st;
        freeze    = fr;
        move_tick = tk;
        grow      = g;
        dir_in    = d[1:0];
        model_edge(st, fr, tk, d, g);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        model_edge(1'b0, 1'b0, 1'b0, int'(dir_in), 1'b0);
    endtask

    task automatic assert_reset_idle();
        start = 1'b0; freeze = 1'b0; move_tick = 1'b0; grow = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_body(input string tag);
        check({tag, "_x"}, snakepos_x, pack_x());
        check({tag, "_y"}, snakepos_y, pack_y());
        check({tag, "_len"}, W'(length), W'(m_len));
    endtask

    // Monitor: every moved pulse must match the oldest expected move.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (moved === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_move actual=moved required=idle cycle=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check("move_cycle", W'(cyc), W'(e.cyc));
                    check("move_x", snakepos_x, e.x);
                    check("move_y", snakepos_y, e.y);
                    check("move_len", W'(length), W'(e.len));
`ifndef SNAKE_WRAP_EN
                    check("move_edge_hit", W'(edge_hit), W'(e.hit));
`endif
                end
            end else if (edge_hit === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL stray_edge_hit actual=1 required=0 cycle=%0d", cyc);
            end
        end
    end

    initial begin
        int sq[4];
        sq[0] = 2; sq[1] = 3; sq[2] = 0; sq[3] = 1;

        model_reset();
        repeat (2) @(negedge clk);
        check_body("reset");
        check("reset_moved", W'(moved), W'(0));
        check("reset_edge_hit", W'(edge_hit), W'(0));
        release_reset();

        // start together with a tick: no move; reversal to LEFT is rejected
        drive(1, 0, 1, 0, 3);
        drive(0, 0, 1, 0, 3);
        drive(0, 0, 0, 0, 3);
        check("first_head_x", W'(snakepos_x[10:0]), W'(340));
        check("first_head_y", W'(snakepos_y[10:0]), W'(240));
        check("first_seg1_x", W'(snakepos_x[21:11]), W'(320));
        check("first_seg2_x", W'(snakepos_x[32:22]), W'(300));
        check("first_len", W'(length), W'(3));
        check("first_moved", W'(moved), W'(1));
        drive(0, 0, 0, 0, 3);
        check("moved_one_cycle", W'(moved), W'(0));

        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("up_head_x", W'(snakepos_x[10:0]), W'(340));
        check("up_head_y", W'(snakepos_y[10:0]), W'(220));

        drive(0, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 1);
        check("grow_len", W'(length), W'(4));
        check("grow_seg3_x", W'(snakepos_x[43:33]), W'(320));
        check("grow_seg3_y", W'(snakepos_y[43:33]), W'(240));

        for (int k = 0; k < 20; k++) drive(0, 0, 1, 1, sq[k % 4]);
        drive(0, 0, 0, 0, 1);
        check("grow_saturate", W'(length), W'(MAX_LEN));

        for (int k = 0; k < 40 && m_x[0] != X_MAX - STEP; k++) drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
`ifdef SNAKE_WRAP_EN
        check("wrap_head_x", W'(snakepos_x[10:0]), W'(0));
`else
        check("edge_head_x", W'(snakepos_x[10:0]), W'(X_MAX - STEP));
        check("edge_hit_pulse", W'(edge_hit), W'(1));
        drive(0, 0, 0, 0, 1);
        check("edge_hit_clear", W'(edge_hit), W'(0));
`endif

        repeat (400) begin
            drive(0, 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
        end

        // freeze wins over a tick; afterwards start and ticks are ignored
        drive(0, 1, 1, 0, int'(dir_in));
        for (int k = 0; k < 6; k++) drive(k == 2, 0, 1, $urandom_range(0, 1), $urandom_range(0, 3));
        drive(0, 0, 0, 0, int'(dir_in));
        check_body("halt_hold");
        check("halt_moved", W'(moved), W'(0));

        @(negedge clk);
        assert_reset_idle();
        model_reset();
        release_reset();
        drive(1, 0, 0, 0, 1);
        repeat (60) begin
            drive(0, 0, $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 3));
        end
        drive(0, 0, 1, 0, int'(dir_in));
        @(posedge clk);
        #2;
        assert_reset_idle();
        #1;
        model_reset();
        check_body("async_reset");
        check("async_reset_moved", W'(moved), W'(0));
        release_reset();

        // back in IDLE: a tick alone must not move
        drive(0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        check("restart_head_x", W'(snakepos_x[10:0]), W'(340));

        repeat (3) drive(0, 0, 0, 0, 1);
        check("scoreboard_drained", W'(sb.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
